spi_reg_decoder: RTL and testbench
==================================

Name: spi_reg_decoder

Overview:
- Parametrised successor of the SPI instruction decoder; sits between the SPI slave byte interface and the register file.
- Decodes a header byte, then moves multi-byte registers (DATA_BYTES wide) over the byte stream, MSB byte first.
- Optional burst mode auto-increments the address.
- Fully synchronous FSM; single-cycle read/write strobes.

Parameters:
- ADDR_W, 6: register address width (1..6; header carries 6 address bits, upper unused bits ignored).
- DATA_BYTES, 2: bytes per register word (1..4); DATA_W = 8*DATA_BYTES.
- NUM_REGS, 64: number of implemented registers, used only by the optional feature (1..2^ADDR_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cs_active  in  1  high while SPI chip-select is asserted; low aborts the frame.
- byte_sync  in  1  one-cycle pulse in the clk domain; data_in is valid in that cycle.
- data_in  in  8  received byte.
- data_out  out  8  byte to shift out on the next SPI byte.
- read  out  1  one-cycle register read strobe.
- write  out  1  one-cycle register write strobe.
- addr  out  ADDR_W  register address; valid whenever read or write is high.
- data_read  in  DATA_W  register read data; combinational, valid in the same cycle as read.
- data_write  out  DATA_W  write data; valid whenever write is high.
- err  out  1  sticky access error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst high, async): state=IDLE; read, write, err = 0; addr, data_write = 0; data_out = 0x00; byte counter = 0.
- Header byte format:
  - bit7: 1 = write, 0 = read.
  - bit6: 1 = burst (auto-increment).
  - bits[ADDR_W-1:0]: start address.
- IDLE: on byte_sync, latch header; go to WR_DATA (write) or RD_FETCH (read).
- WR_DATA:
  - Each byte_sync shifts data_in into the word register (first byte lands in the MSB after DATA_BYTES bytes).
  - On the DATA_BYTES-th byte, write=1 in the next cycle, with addr and data_write stable that cycle.
  - Burst: addr increments after the strobe; stay in WR_DATA and expect the next word.
  - Non-burst: go to DONE.
- RD_FETCH:
  - Entered the cycle after the header byte_sync (or after the last byte of a burst word).
  - read=1 for exactly one cycle; data_read captured into the shift buffer that cycle.
  - data_out = MSB byte from the next cycle; go to RD_SHIFT.
- RD_SHIFT:
  - Each byte_sync advances data_out to the next lower byte on the following cycle.
  - After the DATA_BYTES-th byte_sync:
    - Burst: increment addr, go to RD_FETCH.
    - Non-burst: go to DONE with data_out = 0x00.
- DONE: all byte_sync ignored; data_out = 0x00; no strobes.
- Address arithmetic: increment is modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
- cs_active low, any state, takes priority over byte_sync that cycle:
  - Return to IDLE and clear the byte counter.
  - A partially received write word is discarded (no write strobe).
  - A strobe already scheduled for that cycle still completes.
- read and write are never high in the same cycle.
- Minimum spacing between byte_sync pulses: 3 clk (environment guarantee).
- DATA_BYTES=1: each data byte produces a strobe directly; a read takes one fetch per byte.
- Mid-operation reset: immediate IDLE; no strobe is emitted during or after reset.

Optional Feature:
- Macro: PWMGEN_DCD_RANGE_CHECK_EN.
- Defined:
  - Any access with addr >= NUM_REGS suppresses the read/write strobe.
  - Read data for that access is 0xFF on every byte.
  - err is set to 1 and stays set until rst.
  - Burst continues incrementing and wraps normally; in-range addresses after wrap access normally.
- Undefined: no check; err tied 0; all addresses are accessed.

Test Plan (ADDR_W=6, DATA_BYTES=2, NUM_REGS=8 where relevant):
- Write single, header 0x85 then 0x12, 0x34 -> one write pulse with addr=5, data_write=0x1234; then 0xAA ignored, no further strobe.
- Read single, header 0x03, data_read@addr3=0xBEEF -> one read pulse, addr=3; data_out 0xBE, then 0xEF after 1st byte_sync, 0x00 after 2nd.
- Write burst wrap, header 0xFF then words 0x0001, 0x0002 -> writes at addr 63 (0x0001) then addr 0 (0x0002).
- Read burst, header 0x40, regs 0=0x1111, 1=0x2222 -> reads at 0 then 1; data_out sequence 0x11, 0x11, 0x22, 0x22.
- Abort, header 0x82, byte 0x55, then cs_active low, then new header 0x01 -> no write strobe at all; new read at addr 1 behaves normally.
- With PWMGEN_DCD_RANGE_CHECK_EN, header 0x0A -> no read strobe, data_out 0xFF, 0xFF, err=1 until rst pulse.

Source files
------------

// File: rtl/spi_reg_decoder.sv
// spi_reg_decoder: decodes an SPI header byte and moves DATA_BYTES-wide
// registers over the byte stream, MSB byte first, with optional burst
// auto-increment. Define PWMGEN_DCD_RANGE_CHECK_EN to block accesses at
// addr >= NUM_REGS (reads return 0xFF bytes, sticky err is raised).
module spi_reg_decoder #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_BYTES = 2,
  parameter int unsigned NUM_REGS   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs_active,
  input  logic                    byte_sync,
  input  logic [7:0]              data_in,
  output logic [7:0]              data_out,
  output logic                    read,
  output logic                    write,
  output logic [ADDR_W-1:0]       addr,
  input  logic [8*DATA_BYTES-1:0] data_read,
  output logic [8*DATA_BYTES-1:0] data_write,
  output logic                    err
);

  localparam int unsigned DATA_W = 8 * DATA_BYTES;

`ifdef PWMGEN_DCD_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_FETCH, RD_SHIFT, DONE} state_t;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n, data_write_n, word_in, word_next;
  logic [ADDR_W-1:0] addr_n, addr_inc;
  logic [7:0]        data_out_n;
  logic              burst, burst_n;
  logic              write_n, wdone, wdone_n, err_n;
  logic              last_byte, addr_ok;

  assign word_in   = (shreg << 8) | DATA_W'(data_in);
  assign word_next = shreg << 8;
  assign addr_inc  = addr + ADDR_W'(1);
  assign last_byte = (cnt == 3'(DATA_BYTES - 1));
  assign addr_ok   = !RANGE_CHECK || (32'(addr) < NUM_REGS);

  // The read strobe is a decode of the fetch state, so a fetch already
  // entered still completes even if chip-select drops in that cycle.
  assign read = (state == RD_FETCH) && addr_ok;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      data_write <= '0;
      data_out   <= '0;
      addr       <= '0;
      burst      <= 1'b0;
      write      <= 1'b0;
      wdone      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      data_write <= data_write_n;
      data_out   <= data_out_n;
      addr       <= addr_n;
      burst      <= burst_n;
      write      <= write_n;
      wdone      <= wdone_n;
      err        <= err_n;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shreg_n      = shreg;
    data_write_n = data_write;
    data_out_n   = data_out;
    addr_n       = addr;
    burst_n      = burst;
    write_n      = 1'b0;
    wdone_n      = 1'b0;
    err_n        = err;

    // Burst write address advances in the cycle the strobe is visible.
    if (wdone && burst) addr_n = addr_inc;

    if (state == RD_FETCH && !addr_ok) err_n = 1'b1;

    if (!cs_active) begin
      state_n    = IDLE;
      cnt_n      = '0;
      data_out_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (byte_sync) begin
            addr_n  = data_in[ADDR_W-1:0];
            burst_n = data_in[6];
            cnt_n   = '0;
            shreg_n = '0;
            state_n = data_in[7] ? WR_DATA : RD_FETCH;
          end
        end
        WR_DATA: begin
          if (byte_sync) begin
            shreg_n = word_in;
            if (last_byte) begin
              cnt_n        = '0;
              data_write_n = word_in;
              wdone_n      = 1'b1;
              write_n      = addr_ok;
              if (!addr_ok) err_n = 1'b1;
              state_n      = burst ? WR_DATA : DONE;
            end else begin
              cnt_n = cnt + 3'd1;
            end
          end
        end
        RD_FETCH: begin
          shreg_n    = addr_ok ? data_read : '1;
          data_out_n = addr_ok ? data_read[DATA_W-1 -: 8] : 8'hFF;
          cnt_n      = '0;
          state_n    = RD_SHIFT;
        end
        RD_SHIFT: begin
          if (byte_sync) begin
            if (last_byte) begin
              cnt_n = '0;
              if (burst) begin
                addr_n  = addr_inc;
                state_n = RD_FETCH;
              end else begin
                data_out_n = '0;
                state_n    = DONE;
              end
            end else begin
              shreg_n    = word_next;
              data_out_n = word_next[DATA_W-1 -: 8];
              cnt_n      = cnt + 3'd1;
            end
          end
        end
        DONE: begin
          data_out_n = '0;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Bench for spi_reg_decoder: frame-level reference model predicts strobes and
// shifted-out bytes; one negedge process checks strobes every cycle.
`timescale 1ns/1ps
module tb_spi_reg_decoder;

`ifdef PWMGEN_DCD_RANGE_CHECK_EN
  localparam int unsigned NR = 8;
  localparam bit          RC = 1'b1;
`else
  localparam int unsigned NR = 64;
  localparam bit          RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_active = 1'b0;
  logic        byte_sync = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        read, write, err;
  logic [5:0]  addr;
  logic [15:0] data_read, data_write;

  spi_reg_decoder #(.ADDR_W(6), .DATA_BYTES(2), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .cs_active(cs_active), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(data_out), .read(read), .write(write),
    .addr(addr), .data_read(data_read), .data_write(data_write), .err(err)
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT; contents owned by the model.
  logic [15:0] regs [64];
  assign data_read = regs[addr];

  int vectors = 0;
  int miscompares = 0;

  logic [5:0]  exp_wr_a [$];
  logic [15:0] exp_wr_d [$];
  logic [5:0]  exp_rd_a [$];
  logic [5:0]  wlog_a [$];
  logic [15:0] wlog_d [$];
  int          wr_seen = 0;
  int          rd_seen = 0;
  bit          exp_err = 1'b0;

  logic [7:0]  fb   [16];
  logic [7:0]  expb [16];
  logic [7:0]  dlog [16];
  logic [7:0]  last_dout;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic bit ok(input int unsigned a);
    return !RC || (a < NR);
  endfunction

  // Strobe checker against the predicted access queues
  always @(negedge clk) begin
    check("rw_exclusive", 32'(read & write), 32'd0);
    if (rst) begin
      check("strobe_in_reset", 32'(read | write), 32'd0);
    end else begin
      if (write) begin
        wr_seen++;
        wlog_a.push_back(addr);
        wlog_d.push_back(data_write);
        if (exp_wr_a.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          check("wr_addr", 32'(addr), 32'(exp_wr_a.pop_front()));
          check("wr_data", 32'(data_write), 32'(exp_wr_d.pop_front()));
        end
      end
      if (read) begin
        rd_seen++;
        if (exp_rd_a.size() == 0) check("unexpected_read", 32'd1, 32'd0);
        else check("rd_addr", 32'(addr), 32'(exp_rd_a.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit chk, input logic [7:0] exp);
    repeat ($urandom_range(2, 4)) @(posedge clk);
    #1 byte_sync = 1'b1;
    data_in = b;
    #1 if (chk) check("data_out", 32'(data_out), 32'(exp));
    last_dout = data_out;
    @(posedge clk);
    #1 byte_sync = 1'b0;
    data_in = 8'($urandom);
  endtask

  // One chip-select frame: header plus n bytes from fb, then cs drops.
  task automatic run_frame(input logic [7:0] hdr, input int n);
    int unsigned st, a, nw;
    bit          bu, wr;
    logic [15:0] word;
    st = 32'(hdr[5:0]);
    bu = hdr[6];
    wr = hdr[7];
    if (wr) begin
      nw = bu ? 32'(n / 2) : ((n >= 2) ? 1 : 0);
      for (int unsigned w = 0; w < nw; w++) begin
        a    = (st + w) % 64;
        word = {fb[2*w], fb[2*w+1]};
        if (ok(a)) begin
          exp_wr_a.push_back(6'(a));
          exp_wr_d.push_back(word);
          regs[a] = word;
        end else exp_err = 1'b1;
      end
    end else begin
      nw = bu ? 32'(n / 2 + 1) : 1;
      for (int unsigned w = 0; w < nw; w++) begin
        a = (st + w) % 64;
        if (ok(a)) exp_rd_a.push_back(6'(a));
        else exp_err = 1'b1;
      end
      for (int i = 0; i < n; i++) begin
        if (!bu && i >= 2) expb[i] = 8'h00;
        else begin
          a       = (st + 32'(i / 2)) % 64;
          word    = ok(a) ? regs[a] : 16'hFFFF;
          expb[i] = (i % 2 == 0) ? word[15:8] : word[7:0];
        end
      end
    end
    cs_active = 1'b1;
    repeat (2) @(posedge clk);
    send_byte(hdr, 1'b0, 8'h00);
    for (int i = 0; i < n; i++) begin
      send_byte(fb[i], !wr, expb[i]);
      dlog[i] = last_dout;
    end
    repeat (4) @(posedge clk);
    #1;
    check("pending_writes", 32'(exp_wr_a.size()), 32'd0);
    check("pending_reads", 32'(exp_rd_a.size()), 32'd0);
    check("err", 32'(err), 32'(exp_err));
    exp_wr_a.delete();
    exp_wr_d.delete();
    exp_rd_a.delete();
    cs_active = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_err = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int wc, rc;
    for (int i = 0; i < 64; i++) regs[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data_write", 32'(data_write), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;

    // Single write, trailing byte ignored
    wc = wr_seen;
    fb[0] = 8'h12; fb[1] = 8'h34; fb[2] = 8'hAA;
    run_frame(8'h85, 3);
    check("t1_count", 32'(wr_seen - wc), 32'd1);
    check("t1_addr", 32'(wlog_a[$]), 32'd5);
    check("t1_data", 32'(wlog_d[$]), 32'h1234);

    // Single read
    regs[3] = 16'hBEEF;
    rc = rd_seen;
    fb[0] = 8'h5A; fb[1] = 8'hC3; fb[2] = 8'h0F;
    run_frame(8'h03, 3);
    check("t2_count", 32'(rd_seen - rc), 32'd1);
    check("t2_b0", 32'(dlog[0]), 32'hBE);
    check("t2_b1", 32'(dlog[1]), 32'hEF);
    check("t2_b2", 32'(dlog[2]), 32'h00);

    // Burst write wrapping 63 -> 0
    wc = wr_seen;
    fb[0] = 8'h00; fb[1] = 8'h01; fb[2] = 8'h00; fb[3] = 8'h02;
    run_frame(8'hFF, 4);
`ifdef PWMGEN_DCD_RANGE_CHECK_EN
    check("t3_count", 32'(wr_seen - wc), 32'd1);
    check("t3_err", 32'(err), 32'd1);
`else
    check("t3_count", 32'(wr_seen - wc), 32'd2);
    check("t3_addr0", 32'(wlog_a[wlog_a.size()-2]), 32'd63);
    check("t3_data0", 32'(wlog_d[wlog_d.size()-2]), 32'h0001);
`endif
    check("t3_addr1", 32'(wlog_a[$]), 32'd0);
    check("t3_data1", 32'(wlog_d[$]), 32'h0002);

    // Burst read
    regs[0] = 16'h1111;
    regs[1] = 16'h2222;
    rc = rd_seen;
    for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
    run_frame(8'h40, 4);
    check("t4_reads", 32'(rd_seen - rc), 32'd3);
    check("t4_b0", 32'(dlog[0]), 32'h11);
    check("t4_b1", 32'(dlog[1]), 32'h11);
    check("t4_b2", 32'(dlog[2]), 32'h22);
    check("t4_b3", 32'(dlog[3]), 32'h22);

    // Abort a partial write, then a clean read
    wc = wr_seen;
    fb[0] = 8'h55;
    run_frame(8'h82, 1);
    check("t5_no_write", 32'(wr_seen - wc), 32'd0);
    rc = rd_seen;
    fb[0] = 8'h00; fb[1] = 8'h00;
    run_frame(8'h01, 2);
    check("t5_reads", 32'(rd_seen - rc), 32'd1);
    check("t5_b0", 32'(dlog[0]), 32'h22);
    check("t5_b1", 32'(dlog[1]), 32'h22);

`ifdef PWMGEN_DCD_RANGE_CHECK_EN
    // Out-of-range read
    pulse_reset();
    #1 check("t6_err_clear", 32'(err), 32'd0);
    rc = rd_seen;
    fb[0] = 8'h00; fb[1] = 8'h00;
    run_frame(8'h0A, 2);
    check("t6_no_read", 32'(rd_seen - rc), 32'd0);
    check("t6_b0", 32'(dlog[0]), 32'hFF);
    check("t6_b1", 32'(dlog[1]), 32'hFF);
    check("t6_err_set", 32'(err), 32'd1);
    pulse_reset();
    #1 check("t6_err_after_rst", 32'(err), 32'd0);
`endif

    // Reset on the cycle the last write byte arrives: no strobe
    wc = wr_seen;
    cs_active = 1'b1;
    repeat (2) @(posedge clk);
    send_byte(8'h85, 1'b0, 8'h00);
    send_byte(8'h12, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1 byte_sync = 1'b1;
    data_in = 8'h34;
    rst = 1'b1;
    @(posedge clk);
    #1 byte_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_err = 1'b0;
    check("mr_addr", 32'(addr), 32'd0);
    check("mr_data_write", 32'(data_write), 32'd0);
    check("mr_data_out", 32'(data_out), 32'd0);
    repeat (5) @(posedge clk);
    cs_active = 1'b0;
    repeat (2) @(posedge clk);
    check("mr_no_write", 32'(wr_seen - wc), 32'd0);

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      run_frame(8'($urandom), int'($urandom_range(0, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
